vpl_loop_ctrl: RTL and testbench

- Sequencer for compiled VPL `while` loops: owns the loop index, evaluates the exit condition, and hands each iteration to an external body datapath over a req/ack handshake.
- Generalises the fixed init/step/bound loop into a run-time-configurable controller with an iteration cap.
- Sits between the VPL top-level scheduler (start/done) and a loop-body block.

---
 rtl/vpl_loop_pkg.sv | 25 ++
 rtl/vpl_loop_cond.sv | 20 ++
 rtl/vpl_loop_ctrl.sv | 148 ++++++++++++++
 tb/tb_vpl_loop_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vpl_loop_pkg.sv
// Shared types and helpers for the VPL loop controller.
// Also used by the other generated loop blocks.
package vpl_loop_pkg;

  localparam int DEF_W      = 32;
  localparam int DEF_ITER_W = 16;
  localparam int CMP_W      = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_UPDATE,
    S_HALT
  } state_t;

  // Operands arrive sign-extended to CMP_W; a true signed compare.
  function automatic logic sge(
    input logic signed [CMP_W-1:0] a,
    input logic signed [CMP_W-1:0] b
  );
    return a >= b;
  endfunction

endpackage

// File: rtl/vpl_loop_cond.sv
// Combinational loop exit test: exit_hit = signed(idx) >= signed(bound).
// W may be at most CMP_W.
module vpl_loop_cond
  import vpl_loop_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] idx,
  input  logic [W-1:0] bound,
  output logic         exit_hit
);

  logic signed [W-1:0] idx_s;
  logic signed [W-1:0] bound_s;

  assign idx_s    = idx;
  assign bound_s  = bound;
  assign exit_hit = sge(CMP_W'(idx_s), CMP_W'(bound_s));

endmodule

// File: rtl/vpl_loop_ctrl.sv
// VPL while-loop sequencer with iteration cap and req/ack body handshake.
// Optional abort input/aborted output under VPL_LOOP_CTRL_ABORT_EN.
module vpl_loop_ctrl
  import vpl_loop_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      cfg_init,
  input  logic [W-1:0]      cfg_step,
  input  logic [W-1:0]      cfg_bound,
  input  logic [ITER_W-1:0] cfg_max_iter,
`ifdef VPL_LOOP_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              body_req,
  output logic [W-1:0]      body_idx,
  input  logic              body_ack,
  output logic              busy,
  output logic              done,
  output logic              halt,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  state_t            state_q;
  state_t            state_d;
  logic [W-1:0]      idx_q;
  logic [W-1:0]      step_q;
  logic [W-1:0]      bound_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_nxt;
  logic              timeout_q;
  logic              done_q;
  logic              exit_hit;
  logic              abort_pend;
  logic              accept;
  logic              adv;
  logic              to_set;

  vpl_loop_cond #(.W(W)) u_cond (
    .idx      (idx_q),
    .bound    (bound_q),
    .exit_hit (exit_hit)
  );

  assign cnt_nxt = cnt_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    adv     = 1'b0;
    to_set  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_CHECK;
          accept  = 1'b1;
        end
      end
      S_CHECK: begin
        if (abort_pend || exit_hit) state_d = S_HALT;
        else                        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (body_ack) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        adv = 1'b1;
        // Cap is checked against the post-increment count.
        if (max_q != '0 && cnt_nxt == max_q) begin
          state_d = S_HALT;
          to_set  = 1'b1;
        end else begin
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      step_q    <= '0;
      bound_q   <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_HALT) && (state_q != S_HALT);
      if (accept) begin
        idx_q     <= cfg_init;
        step_q    <= cfg_step;
        bound_q   <= cfg_bound;
        max_q     <= cfg_max_iter;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end
      if (adv) begin
        idx_q <= idx_q + step_q;
        cnt_q <= cnt_nxt;
      end
      if (to_set) timeout_q <= 1'b1;
    end
  end

`ifdef VPL_LOOP_CTRL_ABORT_EN
  logic pend_q;
  logic aborted_q;

  assign abort_pend = pend_q;
  assign aborted    = aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else if (accept) begin
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (abort && busy)                 pend_q    <= 1'b1;
      if (state_q == S_CHECK && pend_q)  aborted_q <= 1'b1;
    end
  end
`else
  assign abort_pend = 1'b0;
`endif

  assign body_req   = (state_q == S_ISSUE);
  assign body_idx   = idx_q;
  assign busy       = (state_q == S_CHECK) || (state_q == S_ISSUE) ||
                      (state_q == S_UPDATE);
  assign halt       = (state_q == S_HALT);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign iter_count = cnt_q;

endmodule

// File: tb/tb_vpl_loop_ctrl.sv
// Directed self-checking bench for vpl_loop_ctrl.
// Abort scenario runs only when VPL_LOOP_CTRL_ABORT_EN is defined.
module tb_vpl_loop_ctrl;

  localparam int W  = 32;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  cfg_init = '0;
  logic [W-1:0]  cfg_step = '0;
  logic [W-1:0]  cfg_bound = '0;
  logic [IW-1:0] cfg_max_iter = '0;
  logic          body_req;
  logic [W-1:0]  body_idx;
  logic          body_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          halt;
  logic          timeout;
  logic [IW-1:0] iter_count;
`ifdef VPL_LOOP_CTRL_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vpl_loop_ctrl #(.W(W), .ITER_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_init     (cfg_init),
    .cfg_step     (cfg_step),
    .cfg_bound    (cfg_bound),
    .cfg_max_iter (cfg_max_iter),
`ifdef VPL_LOOP_CTRL_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .body_req     (body_req),
    .body_idx     (body_idx),
    .body_ack     (body_ack),
    .busy         (busy),
    .done         (done),
    .halt         (halt),
    .timeout      (timeout),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [W-1:0] i, input logic [W-1:0] s,
                    input logic [W-1:0] b, input logic [IW-1:0] m);
    cfg_init     = i;
    cfg_step     = s;
    cfg_bound    = b;
    cfg_max_iter = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (body_req) break;
      tick();
    end
    chk({tag, "_req_seen"}, body_req, 1);
  endtask

  task automatic iter(input string tag, input logic [W-1:0] exp_idx,
                      input int delay);
    wait_req(tag);
    chk({tag, "_idx"}, body_idx, exp_idx);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_hold_req"}, body_req, 1);
      chk({tag, "_hold_idx"}, body_idx, exp_idx);
    end
    body_ack = 1'b1;
    tick();
    body_ack = 1'b0;
    chk({tag, "_req_drop"}, body_req, 0);
  endtask

  task automatic wait_halt(input string tag, input logic [IW-1:0] exp_cnt,
                           input logic exp_to);
    for (int i = 0; i < 16; i++) begin
      if (halt) break;
      tick();
    end
    chk({tag, "_halt"}, halt, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt"}, iter_count, exp_cnt);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_halt_hold"}, halt, 1);
  endtask

  initial begin
    tick();
    chk("rst_req", body_req, 0);
    chk("rst_idx", body_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_halt", halt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", iter_count, 0);
    reset = 1'b0;
    tick();

    // 0,2,4 then exit at 6 >= 5
    go(32'd0, 32'd2, 32'd5, 16'd0);
    chk("t1_busy", busy, 1);
    chk("t1_req_early", body_req, 0);
    tick();
    chk("t1_req_rise", body_req, 1);
    iter("t1_i0", 32'd0, 0);
    iter("t1_i1", 32'd2, 0);
    iter("t1_i2", 32'd4, 0);
    wait_halt("t1", 16'd3, 1'b0);

    // 10 >= -2: no iterations
    go(32'd10, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 16'd0);
    chk("t2_halt_clr", halt, 0);
    chk("t2_cnt_clr", iter_count, 0);
    tick();
    chk("t2_halt_lat", halt, 1);
    chk("t2_no_req", body_req, 0);
    wait_halt("t2", 16'd0, 1'b0);

    // step 0, cap 4
    go(32'd0, 32'd0, 32'd1, 16'd4);
    iter("t3_i0", 32'd0, 0);
    iter("t3_i1", 32'd0, 0);
    iter("t3_i2", 32'd0, 0);
    iter("t3_i3", 32'd0, 0);
    wait_halt("t3", 16'd4, 1'b1);

    // signed max-1 vs signed min: immediate exit
    go(32'h7FFF_FFFE, 32'd1, 32'h8000_0000, 16'd0);
    chk("t4_to_clr", timeout, 0);
    tick();
    chk("t4_halt_lat", halt, 1);
    wait_halt("t4", 16'd0, 1'b0);

    // delayed ack, ignored start, reset mid-handshake
    go(32'd0, 32'd5, 32'd100, 16'd0);
    iter("t5_i0", 32'd0, 5);
    cfg_init = 32'd50;
    cfg_step = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_ign_busy", busy, 1);
    iter("t5_i1", 32'd5, 2);
    wait_req("t5_i2");
    chk("t5_i2_idx", body_idx, 32'd10);
    chk("t5_i2_cnt", iter_count, 16'd2);
    reset = 1'b1;
    #1;
    chk("t5_rst_req", body_req, 0);
    chk("t5_rst_idx", body_idx, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", iter_count, 0);
    chk("t5_rst_halt", halt, 0);
    chk("t5_rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle", busy, 0);

`ifdef VPL_LOOP_CTRL_ABORT_EN
    go(32'd0, 32'd1, 32'd100, 16'd0);
    wait_req("t6");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_req_kept", body_req, 1);
    body_ack = 1'b1;
    tick();
    body_ack = 1'b0;
    wait_halt("t6", 16'd1, 1'b0);
    chk("t6_aborted", aborted, 1);
    go(32'd0, 32'd1, 32'd1, 16'd0);
    chk("t6_ab_clr", aborted, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
